// File: rtl/cntr_arb2_if.sv
// rtl/cntr_arb2_if.sv - requester/counter command bus for the two-way counter arbiter
interface cntr_arb2_if;
  logic       req0;
  logic [1:0] op0;
  logic [7:0] data0;
  logic       req1;
  logic [1:0] op1;
  logic [7:0] data1;
  logic       gnt0;
  logic       gnt1;
  logic       o_load;
  logic       o_inc;
  logic [7:0] o_d_in;
  logic [1:0] o_arb_state;

  modport master (
    output req0, op0, data0, req1, op1, data1,
    input  gnt0, gnt1, o_load, o_inc, o_d_in, o_arb_state
  );

  modport slave (
    input  req0, op0, data0, req1, op1, data1,
    output gnt0, gnt1, o_load, o_inc, o_d_in, o_arb_state
  );
endinterface

// File: rtl/cntr_arb2.sv
// rtl/cntr_arb2.sv - round-robin arbiter with bounded bursts sharing one counter datapath
module cntr_arb2 #(
  parameter int MAX_BURST = 4,
  parameter int BW        = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  cntr_arb2_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  state_t        state, next_state;
  logic          last, next_last;
  logic [BW-1:0] burst_cnt, next_burst;
  logic [1:0]    sel_op;
  logic [7:0]    sel_data;
  logic          granted;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      burst_cnt <= '0;
    end else begin
      state     <= next_state;
      last      <= next_last;
      burst_cnt <= next_burst;
    end
  end

  // burst_cnt only advances while the other side is waiting, so a solo owner is never preempted
  always_comb begin
    next_state = state;
    next_last  = last;
    next_burst = burst_cnt;
    case (state)
      IDLE: begin
        next_burst = '0;
        if (bus.req0 && bus.req1) next_state = last ? GNT0 : GNT1;
        else if (bus.req0)        next_state = GNT0;
        else if (bus.req1)        next_state = GNT1;
      end
      GNT0: begin
        if (!bus.req0) begin
          next_last  = 1'b0;
          next_burst = '0;
          next_state = bus.req1 ? GNT1 : IDLE;
        end else if (bus.req1) begin
          if (burst_cnt == BURST_LAST) begin
            next_state = GNT1;
            next_last  = 1'b0;
            next_burst = '0;
          end else begin
            next_burst = burst_cnt + BW'(1);
          end
        end else begin
          next_burst = '0;
        end
      end
      GNT1: begin
        if (!bus.req1) begin
          next_last  = 1'b1;
          next_burst = '0;
          next_state = bus.req0 ? GNT0 : IDLE;
        end else if (bus.req0) begin
          if (burst_cnt == BURST_LAST) begin
            next_state = GNT0;
            next_last  = 1'b1;
            next_burst = '0;
          end else begin
            next_burst = burst_cnt + BW'(1);
          end
        end else begin
          next_burst = '0;
        end
      end
      default: begin
        next_state = IDLE;
        next_burst = '0;
      end
    endcase
  end

  // Commands are gated by reset_n so nothing reaches the counter during a reset cycle
  always_comb begin
    bus.gnt0        = (state == GNT0);
    bus.gnt1        = (state == GNT1);
    bus.o_arb_state = state;
    granted         = reset_n && (state == GNT0 || state == GNT1);
    sel_op          = (state == GNT1) ? bus.op1 : bus.op0;
    sel_data        = (state == GNT1) ? bus.data1 : bus.data0;
    bus.o_load      = granted && (sel_op == 2'b10);
    bus.o_inc       = granted && (sel_op == 2'b01);
    bus.o_d_in      = bus.o_load ? sel_data : 8'h00;
  end

endmodule

// File: tb/tb_cntr_arb2.sv
// tb/tb_cntr_arb2.sv - randomized and directed self-checking bench for cntr_arb2
module tb_cntr_arb2;
  localparam int MAX = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   n_err = 0;
  int   n_chk = 0;

  // reference model: owner -1 idle, 0/1 requester; run counts contended cycles served
  int   m_owner;
  int   m_last;
  int   m_run;
  logic [7:0] tb_cnt;
  logic own_req, oth_req;

  cntr_arb2_if bus();

  cntr_arb2 #(.MAX_BURST(MAX), .BW(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  assign own_req = (m_owner == 0) ? bus.req0 : bus.req1;
  assign oth_req = (m_owner == 0) ? bus.req1 : bus.req0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_owner <= -1;
      m_last  <= 1;
      m_run   <= 0;
      tb_cnt  <= 8'h00;
    end else begin
      if (bus.o_load)     tb_cnt <= bus.o_d_in;
      else if (bus.o_inc) tb_cnt <= tb_cnt + 8'h01;
      if (m_owner < 0) begin
        m_run <= 0;
        if (bus.req0 && bus.req1) m_owner <= (m_last == 1) ? 0 : 1;
        else if (bus.req0)        m_owner <= 0;
        else if (bus.req1)        m_owner <= 1;
      end else if (!own_req) begin
        m_last  <= m_owner;
        m_owner <= oth_req ? 1 - m_owner : -1;
        m_run   <= 0;
      end else if (oth_req && (m_run + 1 == MAX)) begin
        m_last  <= m_owner;
        m_owner <= 1 - m_owner;
        m_run   <= 0;
      end else begin
        m_run <= oth_req ? m_run + 1 : 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // apply inputs for one cycle, then compare every output against the model
  task automatic cyc(input logic rn, input logic r0, input logic [1:0] o0, input logic [7:0] d0,
                     input logic r1, input logic [1:0] o1, input logic [7:0] d1);
    logic [1:0] op;
    logic [7:0] dat;
    logic       e_load, e_inc;
    @(negedge clk);
    reset_n   = rn;
    bus.req0  = r0; bus.op0 = o0; bus.data0 = d0;
    bus.req1  = r1; bus.op1 = o1; bus.data1 = d1;
    #1;
    op     = (m_owner == 1) ? o1 : o0;
    dat    = (m_owner == 1) ? d1 : d0;
    e_load = rn && (m_owner >= 0) && (op == 2'b10);
    e_inc  = rn && (m_owner >= 0) && (op == 2'b01);
    check("gnt0",  32'(bus.gnt0), 32'(m_owner == 0));
    check("gnt1",  32'(bus.gnt1), 32'(m_owner == 1));
    check("state", 32'(bus.o_arb_state), (m_owner < 0) ? 32'd0 : (m_owner == 0 ? 32'd1 : 32'd2));
    check("load",  32'(bus.o_load), 32'(e_load));
    check("inc",   32'(bus.o_inc), 32'(e_inc));
    check("d_in",  32'(bus.o_d_in), e_load ? 32'(dat) : 32'd0);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 2'b00, 8'h00);
    cyc(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 2'b00, 8'h00);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.req0 = 1'b0; bus.op0 = 2'b00; bus.data0 = 8'h00;
    bus.req1 = 1'b0; bus.op1 = 2'b00; bus.data1 = 8'h00;
    m_owner = -1; m_last = 1; m_run = 0; tb_cnt = 8'h00;
    do_reset();

    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 2'b00, 8'h00);
      check("rst_state", 32'(bus.o_arb_state), 32'd0);
      check("rst_cmd", 32'({bus.gnt0, bus.gnt1, bus.o_load, bus.o_inc}), 32'd0);
    end

    // single load from requester 0
    cyc(1'b1, 1'b1, 2'b10, 8'hA5, 1'b0, 2'b00, 8'h00);
    check("c0_no_load", 32'(bus.o_load), 32'd0);
    cyc(1'b1, 1'b1, 2'b10, 8'hA5, 1'b0, 2'b00, 8'h00);
    check("c1_gnt0", 32'(bus.gnt0), 32'd1);
    check("c1_load", 32'(bus.o_load), 32'd1);
    check("c1_d_in", 32'(bus.o_d_in), 32'hA5);
    cyc(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 2'b00, 8'h00);
    cyc(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 2'b00, 8'h00);
    check("c3_idle", 32'(bus.o_arb_state), 32'd0);

    // continuous contention, both incrementing
    do_reset();
    for (int c = 0; c <= 9; c++) begin
      cyc(1'b1, 1'b1, 2'b01, 8'h00, 1'b1, 2'b01, 8'h00);
      if (c >= 1 && c <= 4) check("burst_gnt0", 32'(bus.gnt0), 32'd1);
      if (c >= 5 && c <= 8) check("burst_gnt1", 32'(bus.gnt1), 32'd1);
    end
    check("burst_back0", 32'(bus.gnt0), 32'd1);
    check("cnt_eq_8", 32'(tb_cnt), 32'd8);

    // solo requester 1 is never preempted
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      cyc(1'b1, 1'b0, 2'b00, 8'h00, 1'b1, 2'b01, 8'h00);
      if (c >= 1) check("solo_gnt1", 32'(bus.gnt1), 32'd1);
    end

    // release handoff without an idle bubble
    do_reset();
    cyc(1'b1, 1'b1, 2'b00, 8'h00, 1'b0, 2'b00, 8'h00);
    cyc(1'b1, 1'b0, 2'b00, 8'h00, 1'b1, 2'b10, 8'h3C);
    check("ho_gnt0", 32'(bus.gnt0), 32'd1);
    cyc(1'b1, 1'b0, 2'b00, 8'h00, 1'b1, 2'b10, 8'h3C);
    check("ho_gnt1", 32'(bus.gnt1), 32'd1);
    check("ho_load", 32'(bus.o_load), 32'd1);
    check("ho_d_in", 32'(bus.o_d_in), 32'h3C);

    // reset in the middle of a GNT1 burst
    do_reset();
    cyc(1'b1, 1'b0, 2'b00, 8'h00, 1'b1, 2'b01, 8'h00);
    cyc(1'b1, 1'b0, 2'b00, 8'h00, 1'b1, 2'b01, 8'h00);
    cyc(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 2'b01, 8'h00);
    check("mr_no_inc", 32'(bus.o_inc), 32'd0);
    cyc(1'b1, 1'b1, 2'b01, 8'h00, 1'b1, 2'b01, 8'h00);
    check("mr_idle", 32'(bus.o_arb_state), 32'd0);
    check("mr_cmd", 32'({bus.gnt0, bus.gnt1, bus.o_load, bus.o_inc}), 32'd0);
    cyc(1'b1, 1'b1, 2'b01, 8'h00, 1'b1, 2'b01, 8'h00);
    check("mr_first0", 32'(bus.gnt0), 32'd1);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) != 0,
          1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom),
          1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom));
      check("excl", 32'(bus.gnt0 && bus.gnt1), 32'd0);
      check("ld_inc", 32'(bus.o_load && bus.o_inc), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
